// File: rtl/fifo_pkg.sv
// Shared sizing helpers for the synchronous FIFO family.
// Latency: n/a (compile-time functions only).
// Backpressure: n/a.
package fifo_pkg;

   // Occupancy counter must hold 0..depth inclusive.
   function automatic int count_width(input int depth);
      return $clog2(depth) + 1;
   endfunction

   // Read/write pointers index 0..depth-1.
   function automatic int ptr_width(input int depth);
      return $clog2(depth);
   endfunction

endpackage

// File: rtl/fifo_sync_if.sv
// Valid/ready word channel between same-clock FIFO stages.
// Latency: n/a (wires only).
// Backpressure: enable is held by the master until ready is seen on an edge.
interface fifo_sync_if #(
   parameter int width = 8
);
   logic [width-1:0] data;
   logic             enable;
   logic             ready;

   // Producer side of the channel.
   modport master (output data, output enable, input ready);
   // Consumer side of the channel.
   modport slave  (input data, input enable, output ready);
endinterface

// File: rtl/fifo_ram.sv
// Dual-port storage array: synchronous write, asynchronous read.
// Latency: write visible on the read port after the writing edge; read is combinational.
// Backpressure: none; the caller gates we_i.
module fifo_ram
   import fifo_pkg::*;
#(
   parameter  int width = 8,
   parameter  int depth = 16,
   localparam int PW    = ptr_width(depth)
) (
   input  logic             clk_i,
   input  logic             we_i,
   input  logic [PW-1:0]    waddr_i,
   input  logic [width-1:0] wdata_i,
   input  logic [PW-1:0]    raddr_i,
   output logic [width-1:0] rdata_o
);

   logic [width-1:0] mem_q [depth];

   // Contents are deliberately not reset; only the pointers define validity.
   always_ff @(posedge clk_i) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/fifo_sync.sv
// Single-clock first-word-fall-through FIFO with occupancy count. Optional macro: FIFO_SYNC_CHECK_EN.
// Latency: a word pushed on edge N is presented on out_if after edge N (1 cycle).
// Backpressure: in_if.ready drops at count==depth (no full bypass); flags depend on registered state only.
module fifo_sync
   import fifo_pkg::*;
#(
   parameter  int width = 8,
   parameter  int depth = 16,
   localparam int PW    = ptr_width(depth),
   localparam int CW    = count_width(depth)
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   fifo_sync_if.slave           in_if,
   fifo_sync_if.master          out_if,
   output logic [CW-1:0]        count_o
);

   localparam logic [PW-1:0] LAST_PTR = PW'(depth - 1);
   localparam logic [CW-1:0] FULL_CNT = CW'(depth);

   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q,  count_d;
   logic          in_rdy;
   logic          out_vld;
   logic          push;
   logic          pop;

   // Ready is forced low while reset is held, even though count is already 0.
   assign in_rdy  = rst_ni && (count_q != FULL_CNT);
   assign out_vld = (count_q != '0);

   // Handshake decode and next-state for pointers and occupancy.
   always_comb begin
      push     = in_if.enable && in_rdy;
      pop      = out_if.ready && out_vld;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push) begin
         wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + 1'b1;
      end
      if (pop) begin
         rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + 1'b1;
      end
      if (push && !pop) begin
         count_d = count_q + 1'b1;
      end else if (pop && !push) begin
         count_d = count_q - 1'b1;
      end
   end

   // Pointer and occupancy registers, cleared asynchronously.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   fifo_ram #(
      .width (width),
      .depth (depth)
   ) u_ram (
      .clk_i   (clk_i),
      .we_i    (push),
      .waddr_i (wr_ptr_q),
      .wdata_i (in_if.data),
      .raddr_i (rd_ptr_q),
      .rdata_o (out_if.data)
   );

   assign in_if.ready   = in_rdy;
   assign out_if.enable = out_vld;
   assign count_o       = count_q;

`ifdef FIFO_SYNC_CHECK_EN
   // Report dropped writes and any occupancy/pointer inconsistency.
   always_ff @(posedge clk_i) begin
      if (rst_ni) begin
         if (in_if.enable && !in_rdy) begin
            $display("%t %m: write while full, word dropped", $time);
         end
         if (count_q > FULL_CNT) begin
            $error("%m: count %0d exceeds depth %0d", count_q, depth);
         end
         if (((int'(wr_ptr_q) - int'(rd_ptr_q) + depth) % depth) != (int'(count_q) % depth)) begin
            $error("%m: count %0d disagrees with pointers wr=%0d rd=%0d", count_q, wr_ptr_q, rd_ptr_q);
         end
      end
   end
`endif

endmodule

// File: tb/tb_fifo_sync.sv
// Randomized self-checking bench for fifo_sync against a queue reference model.
// Latency: checks every cycle on the falling edge against the model's pre-edge state.
// Backpressure: model predicts acceptance from its own occupancy (no full bypass).
module tb_fifo_sync;

   localparam int W  = 16;
   localparam int D  = 512;
   localparam int CW = $clog2(D) + 1;

   logic          clk;
   logic          rst_n;
   logic [CW-1:0] count;

   fifo_sync_if #(.width(W)) in_if ();
   fifo_sync_if #(.width(W)) out_if ();

   fifo_sync #(
      .width (W),
      .depth (D)
   ) dut (
      .clk_i   (clk),
      .rst_ni  (rst_n),
      .in_if   (in_if),
      .out_if  (out_if),
      .count_o (count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int unsigned   n_vec;
   int unsigned   n_err;
   logic [W-1:0]  model [$];
   logic [W-1:0]  out_log [$];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // One clock: drive inputs, check outputs before the edge, advance model after it.
   task automatic step(input logic en, input logic [W-1:0] d, input logic rdy);
      bit           do_push;
      bit           do_pop;
      logic [W-1:0] w;
      in_if.enable  = en;
      in_if.data    = d;
      out_if.ready  = rdy;
      @(negedge clk);
      chk("count",   32'(count), 32'(model.size()));
      chk("in_rdy",  32'(in_if.ready), 32'(model.size() != D));
      chk("out_en",  32'(out_if.enable), 32'(model.size() != 0));
      if (model.size() != 0) chk("out_dat", 32'(out_if.data), 32'(model[0]));
      do_push = en  && (model.size() < D);
      do_pop  = rdy && (model.size() > 0);
      @(posedge clk);
      if (do_pop) begin
         w = model.pop_front();
         out_log.push_back(w);
      end
      if (do_push) model.push_back(d);
      #1;
   endtask

   initial begin
      int unsigned next_val;
      n_vec = 0;
      n_err = 0;
      in_if.enable = 1'b0;
      in_if.data   = '0;
      out_if.ready = 1'b0;
      rst_n        = 1'b0;

      // Reset held.
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_count",  32'(count), 0);
      chk("rst_in_rdy", 32'(in_if.ready), 0);
      chk("rst_out_en", 32'(out_if.enable), 0);
      rst_n = 1'b1;
      #1;
      chk("rel_in_rdy", 32'(in_if.ready), 1);
      chk("rel_out_en", 32'(out_if.enable), 0);
      chk("rel_count",  32'(count), 0);
      @(posedge clk);
      #1;

      // Single word in and out.
      step(1'b1, 16'hA5A5, 1'b0);
      step(1'b0, '0, 1'b0);
      chk("single_dat", 32'(out_if.data), 32'h0000A5A5);
      step(1'b0, '0, 1'b1);
      step(1'b0, '0, 1'b0);
      out_log.delete();

      // Order and wrap: 0..1023 streamed with occasional consumer gaps.
      next_val = 0;
      for (int i = 0; i < 6000 && (next_val < 1024 || model.size() != 0); i++) begin
         logic en;
         logic rdy;
         en  = (next_val < 1024);
         rdy = ($urandom_range(0, 7) != 0);
         if (en && model.size() < D) begin
            step(1'b1, W'(next_val), rdy);
            next_val++;
         end else begin
            step(en, W'(next_val), rdy);
         end
      end
      chk("seq_len", 32'(out_log.size()), 1024);
      for (int i = 0; i < out_log.size(); i++) begin
         chk("seq", 32'(out_log[i]), 32'(i));
      end
      out_log.delete();

      // Fill to full with the consumer stalled.
      for (int i = 0; i < D; i++) step(1'b1, W'($urandom), 1'b0);
      step(1'b1, 16'hDEAD, 1'b0);
      chk("full_count", 32'(count), D);
      chk("full_in_rdy", 32'(in_if.ready), 0);
      // Full with push and pop offered: only the pop happens.
      step(1'b1, 16'hBEEF, 1'b1);
      chk("full_pop_count", 32'(count), D - 1);

      // Drain to 5, then sustained simultaneous push/pop.
      for (int i = 0; i < 2 * D && model.size() > 5; i++) step(1'b0, '0, 1'b1);
      for (int i = 0; i < 20; i++) step(1'b1, W'($urandom), 1'b1);
      step(1'b0, '0, 1'b0);
      chk("pp_count5", 32'(count), 5);

      // Random traffic.
      for (int i = 0; i < 3000; i++) begin
         step($urandom_range(0, 3) != 0, W'($urandom), $urandom_range(0, 3) != 0);
      end

      // Drain, then build up 37 words and reset mid-stream.
      for (int i = 0; i < 2 * D && model.size() > 0; i++) step(1'b0, '0, 1'b1);
      for (int i = 0; i < 37; i++) step(1'b1, W'($urandom), 1'b0);
      step(1'b0, '0, 1'b0);
      chk("pre_rst_count", 32'(count), 37);
      #2;
      rst_n = 1'b0;
      #1;
      chk("mid_rst_count",  32'(count), 0);
      chk("mid_rst_out_en", 32'(out_if.enable), 0);
      chk("mid_rst_in_rdy", 32'(in_if.ready), 0);
      model.delete();
      @(posedge clk);
      #2;
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Pop attempts while empty, then the next word is the first delivered.
      for (int i = 0; i < 10; i++) step(1'b0, '0, 1'b1);
      chk("empty_count", 32'(count), 0);
      out_log.delete();
      step(1'b1, 16'h1234, 1'b1);
      step(1'b0, '0, 1'b1);
      step(1'b0, '0, 1'b0);
      chk("empty_first_len", 32'(out_log.size()), 1);
      if (out_log.size() != 0) chk("empty_first_dat", 32'(out_log[0]), 32'h1234);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/fifo_sync.md
# fifo_sync

Single-clock, first-word-fall-through FIFO with ready/enable handshakes on both sides and an occupancy count. It is the generic buffering block used wherever two same-clock FIFOInterface stages must be decoupled, for example the 16-bit, 512-deep in/out buffers of the FX2 host-interface model. Storage is a simple register/RAM array; no clock crossing.

## Interface
Parameters:
- width, 8, data word width in bits
- depth, 16, number of words stored; any integer ≥ 2

Ports (clock and reset from the ClockReset bundle `cr`; data ports are FIFOInterface bundles):
- cr.clk  input  1  clock; all state changes on the rising edge
- cr.reset  input  1  asynchronous, active-low reset (asserted at 0)
- in.data  input  width  write data
- in.enable  input  1  producer offers a word
- in.ready  output  1  FIFO can accept a word
- out.data  output  width  head-of-queue word
- out.enable  output  1  head word valid (FIFO non-empty)
- out.ready  input  1  consumer accepts the head word
- count  output  $clog2(depth)+1  current occupancy, 0..depth

## Operation
- Push: occurs on a clock edge when in.enable && in.ready. in.data is written at the write pointer, which then advances.
- Pop: occurs on a clock edge when out.enable && out.ready. The read pointer advances.
- Pointers are $clog2(depth) bits wide. Each wraps from depth-1 to 0; depth need not be a power of two.
- count: next = count + push - pop. A simultaneous push and pop leaves count unchanged.
- in.ready = (count != depth) while reset is deasserted.
- out.enable = (count != 0). out.data = mem[rd_ptr] as a combinational read, so the head word is presented with no read latency.
- Full: in.ready is 0 and in.enable is ignored. A pop in the same cycle does not enable a push; there is no full bypass.
- Empty: out.enable is 0 and out.ready is ignored. There is no write-to-read bypass.
- out.data when empty is don't-care. It holds the stale mem[rd_ptr].
- Memory contents are not reset.

## Timing
- Reset asserted (at any time, including mid-transfer): wr_ptr, rd_ptr and count go to 0 immediately. in.ready=0 and out.enable=0 for as long as reset is held.
- Reset deasserted: the first edge that can push is the first rising edge after release. in.ready=1 from release.
- Write-to-read latency is 1 cycle. A word pushed at edge N appears on out.data with out.enable=1 after edge N when the FIFO was empty.
- count, in.ready and out.enable are derived from registered state only. They do not depend combinationally on in.enable or out.ready, so there are no combinational paths through the FIFO.
- Throughput: 1 push and 1 pop per cycle sustained.

## Configuration
- FIFO_SYNC_CHECK_EN defined: simulation-only checks are compiled in.
  - A $display with %t and %m is issued on any edge where in.enable=1 and in.ready=0 ("write while full, word dropped").
  - An $error is raised if count ever exceeds depth or disagrees with the pointer difference.
- Not defined: no checks, identical synthesizable RTL.

## Structure
- Shared package fifo_pkg:
  - count_width(depth) function returning $clog2(depth)+1
  - ptr_width(depth) function returning $clog2(depth)
- Sub-module fifo_ram: a dual-port array with synchronous write (we, waddr, wdata) and asynchronous read (raddr → rdata), parameterized by width and depth.
- fifo_sync contains the pointers, count, and handshake logic.

## Test plan
All cases use width=16, depth=512.
- Reset: hold cr.reset=0, then release → count=0, out.enable=0, in.ready=1. Asserting reset mid-stream with count=37 → count=0 and out.enable=0 immediately.
- Single word: push 16'hA5A5 at edge N → out.enable=1, out.data=16'hA5A5 and count=1 after edge N. Pop with out.ready=1 → count=0, out.enable=0.
- Order and wrap: push 0..1023 while popping continuously with occasional out.ready gaps → output sequence is 0..1023 exactly with no loss, exercising pointer wrap at 511→0.
- Fill to full: push 512 words with out.ready=0 → count=512 and in.ready=0. A 513th push with in.enable=1 is ignored, and the warning is printed if FIFO_SYNC_CHECK_EN is defined. The first pop then yields word 0.
- Simultaneous push and pop at count=5 → count stays 5 and data order is preserved. At count=512 with out.ready=1 and in.enable=1 → count becomes 511 because no push occurs.
- Empty pop: out.ready=1 with count=0 for 10 cycles → count stays 0, and the next pushed word is the first one delivered.
